// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each stage adds one SW-bit slice built from 4-bit lookahead groups and
// passes its carry, the partial sum and the unconsumed operand bits onward.
module pipe_cla_adder #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SLICE_GROUPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned SW  = 4 * SLICE_GROUPS;
  localparam int unsigned LAT = WIDTH / SW;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // One SW-bit slice: 4-bit lookahead groups, group G/P rippled between them.
  // Returns {carry out, sum}.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] c;
    logic [3:0]    gg;
    logic [3:0]    gp;
    logic          cg;
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    cg = ci;
    for (int unsigned j = 0; j < SLICE_GROUPS; j++) begin
      gg = g[4*j +: 4];
      gp = p[4*j +: 4];
      c[4*j]   = cg;
      c[4*j+1] = gg[0] | (gp[0] & cg);
      c[4*j+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg);
      c[4*j+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cg);
      cg = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cg);
    end
    return {cg, p ^ c};
  endfunction

  // Subtraction folds into the operands: invert b and force carry-in to 1.
  always_comb begin
    b_eff = sub ? ~b : b;
    cin0  = sub | c0;
  end

  // Whole pipeline moves together unless a valid result is being held.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int unsigned IN_W  = WIDTH - k * SW;
    localparam int unsigned OUT_W = WIDTH - (k + 1) * SW;

    logic [IN_W-1:0]      a_in;
    logic [IN_W-1:0]      b_in;
    logic                 c_in;
    logic                 v_in;
    logic [SW:0]          slice;
    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*SW-1:0]  sum_q;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = cin0;
      assign v_in = in_valid;

      // First slice of the sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      sum_q <= '0;
        else if (adv) sum_q <= slice[SW-1:0];
      end
    end else begin : g_src
      assign a_in = g_stage[k-1].g_rem.a_q;
      assign b_in = g_stage[k-1].g_rem.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;

      // Append this slice above the sum bits already produced.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      sum_q <= '0;
        else if (adv) sum_q <= {slice[SW-1:0], g_stage[k-1].sum_q};
      end
    end

    // Lookahead addition of the lowest remaining slice.
    always_comb begin
      slice = cla_slice(a_in[SW-1:0], b_in[SW-1:0], c_in);
    end

    // Slice carry and beat valid travel with the data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= slice[SW];
      end
    end

    if (OUT_W > 0) begin : g_rem
      logic [OUT_W-1:0] a_q;
      logic [OUT_W-1:0] b_q;

      // Carry the not-yet-added operand bits to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IN_W-1:SW];
          b_q <= b_in[IN_W-1:SW];
        end
      end
    end else begin : g_msb
      logic cm_q;

      // Carry into the MSB, recovered from the MSB sum and operand bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      cm_q <= 1'b0;
        else if (adv) cm_q <= slice[SW-1] ^ a_in[SW-1] ^ b_in[SW-1];
      end
    end
  end

  assign out_valid = g_stage[LAT-1].v_q;
  assign s         = g_stage[LAT-1].sum_q;
  assign c_out     = g_stage[LAT-1].c_q;
  assign ovf       = g_stage[LAT-1].g_msb.cm_q ^ g_stage[LAT-1].c_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder in three configurations:
// 16/2 (LAT=2, directed + stream + backpressure + reset), 8/2 (LAT=1)
// and 32/1 (LAT=8) with random valid/ready traffic.
module tb_pipe_cla_adder;

  logic        clk = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar cfg = 0; cfg < 3; cfg++) begin : g_cfg
    localparam int W = (cfg == 0) ? 16 : (cfg == 1) ? 8 : 32;
    localparam int G = (cfg == 2) ? 1 : 2;
    localparam int L = W / (4 * G);

    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         c0        = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         done      = 1'b0;

    logic [W+1:0] exp_q[$];
    int unsigned  tag_q[$];
    int unsigned  adv_cnt   = 0;
    int unsigned  pops      = 0;
    logic         hold_v    = 1'b0;
    logic [W+2:0] held      = '0;

    pipe_cla_adder #(.WIDTH(W), .SLICE_GROUPS(G)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c0(c0), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    // Reference: plain integer arithmetic, signed overflow from operand signs.
    function automatic logic [W+1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic sb);
      logic [W-1:0] ye;
      logic [W:0]   full;
      ye   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      return {(x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]), full};
    endfunction

    // Issue side: record each accepted beat's expected result and advance tag.
    always @(negedge clk) begin
      if (!rst) begin
        if (in_ready) adv_cnt <= adv_cnt + 1;
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_res(a, b, c0, sub));
          tag_q.push_back(adv_cnt);
        end
      end
    end

    // Monitor: compare delivered results, latency and stall stability.
    always @(negedge clk) begin : mon
      logic [W+1:0] e;
      int unsigned  t;
      if (rst) begin
        exp_q.delete();
        tag_q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk($sformatf("cfg%0d_hold_stable", cfg), {out_valid, ovf, c_out, s}, held);
        hold_v = out_valid && !out_ready;
        held   = {out_valid, ovf, c_out, s};
        if (out_valid && out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg%0d_unexpected_out: got s=0x%0h, expected no beat", cfg, s);
          end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk($sformatf("cfg%0d_result", cfg), {ovf, c_out, s}, e);
            chk($sformatf("cfg%0d_latency", cfg), adv_cnt - t, L);
          end
        end
      end
    end

    if (cfg == 0) begin : g_main
      task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, output int unsigned waited);
        waited   = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        c0       = ci;
        sub      = sb;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
          waited++;
          @(negedge clk);
        end
        chk("accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      endtask

      task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic ci, input logic sb,
                              input logic [W-1:0] es, input logic ec, input logic eo);
        int unsigned w;
        send(x, y, ci, sb, w);
        repeat (L - 1) @(posedge clk);
        @(negedge clk);
        chk("directed", {out_valid, c_out, ovf, s}, {1'b1, ec, eo, es});
        @(posedge clk);
        #1;
      endtask

      initial begin
        int unsigned w;
        int unsigned p0;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h4321;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {out_valid, c_out, ovf, s}, '0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;

        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        p0 = pops;
        for (int i = 0; i < 100; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
          chk("stream_in_ready", w, 0);
        end
        repeat (L + 1) @(posedge clk);
        @(negedge clk);
        chk("stream_count", pops - p0, 100);
        @(posedge clk);
        #1;

        p0        = pops;
        out_ready = 1'b0;
        fork
          begin
            int unsigned wb;
            for (int i = 0; i < 3; i++)
              send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wb);
          end
          begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_no_pop", pops - p0, 0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        join
        repeat (L + 2) @(posedge clk);
        @(negedge clk);
        chk("bp_drained", pops - p0, 3);
        @(posedge clk);
        #1;

        p0        = pops;
        out_ready = 1'b0;
        send(16'h4000, 16'h4000, 1'b0, 1'b0, w);
        send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, w);
        chk("pre_rst_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        #1;
        chk("rst_clears", {out_valid, c_out, ovf, s}, '0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, w);
        chk("post_rst_first_accept", w, 0);
        repeat (2 * L + 4) @(posedge clk);
        @(negedge clk);
        chk("post_rst_count", pops - p0, 1);
        chk("cfg0_queue_empty", exp_q.size(), 0);
        done = 1'b1;
      end
    end else begin : g_rand
      initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk($sformatf("cfg%0d_reset_state", cfg), {out_valid, c_out, ovf, s}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
          in_valid  = ($urandom_range(0, 9) < 7);
          a         = W'($urandom);
          b         = W'($urandom);
          c0        = 1'($urandom_range(0, 1));
          sub       = 1'($urandom_range(0, 1));
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk);
          #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (L + 4) @(posedge clk);
        @(negedge clk);
        chk($sformatf("cfg%0d_drain_empty", cfg), exp_q.size(), 0);
        chk($sformatf("cfg%0d_some_output", cfg), (pops > 50), 1);
        done = 1'b1;
      end
    end
  end

  initial begin
    int unsigned cyc;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished configurations, expected all done within %0d cycles", cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand width in bits; legal values are multiples of 4*SLICE_GROUPS and at least 4*SLICE_GROUPS.
REQ-002 The block SHALL take parameter SLICE_GROUPS, default 2, as the number of 4-bit lookahead groups evaluated per pipeline stage.
REQ-003 The block SHALL define derived constants SW = 4*SLICE_GROUPS (slice width) and LAT = WIDTH/SW (pipeline stages, and latency in cycles).
REQ-004 Port clk  input  1  is the single clock; every register SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  SHALL indicate that the operand beat is valid.
REQ-007 Port in_ready  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-008 Port a  input  WIDTH  SHALL carry operand A.
REQ-009 Port b  input  WIDTH  SHALL carry operand B.
REQ-010 Port c0  input  1  SHALL be the carry-in, used only when sub=0.
REQ-011 Port sub  input  1  SHALL select the operation: 0 = add, 1 = subtract.
REQ-012 Port out_valid  output  1  SHALL indicate that the result beat is valid.
REQ-013 Port out_ready  input  1  SHALL indicate that the downstream consumer takes the result.
REQ-014 Port s  output  WIDTH  SHALL carry the result.
REQ-015 Port c_out  output  1  SHALL be the carry out of the MSB (1 = no borrow when subtracting).
REQ-016 Port ovf  output  1  SHALL flag two's-complement signed overflow.

Function
REQ-017 Operation SHALL be: sub=0 gives {c_out,s} = a + b + c0; sub=1 gives {c_out,s} = a + ~b + 1, with c0 ignored.
REQ-018 ovf SHALL equal (carry into MSB) XOR c_out, using the effective (possibly inverted) b.
REQ-019 Each slice SHALL be built from SLICE_GROUPS 4-bit carry-lookahead groups: per-bit g = a&b and p = a^b, a full 4-bit lookahead carry inside each group, and group G/P rippled between groups within the slice.
REQ-020 Stage k (k = 0..LAT-1) SHALL compute bits [k*SW +: SW] using the carry registered by stage k-1; stage 0 SHALL use c0 when sub=0 and 1 when sub=1.
REQ-021 Stage registers SHALL hold the sum bits already produced, the unconsumed upper slices of a and effective b, the slice carry, the carry into bit WIDTH-1, and a per-stage valid bit.
REQ-022 A global advance signal SHALL be defined as adv = !out_valid || out_ready, and all stage registers, including valid bits, SHALL load only when adv=1.
REQ-023 in_ready SHALL equal adv; this is a combinational path from out_ready and out_valid.
REQ-024 A beat SHALL be accepted when in_valid && in_ready, and its result SHALL appear at s, c_out and ovf with out_valid=1 exactly LAT advancing cycles later.
REQ-025 Full throughput SHALL be one beat per cycle while out_ready=1, with no bubbles inserted.
REQ-026 When adv=0, all stage contents SHALL hold, and s, c_out, ovf and out_valid SHALL remain stable until the handshake completes.
REQ-027 When adv=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0; bubbles SHALL propagate and never raise out_valid.
REQ-028 s, c_out and ovf SHALL be driven directly from the last stage's registers, with no combinational path from a, b or c0 to any output.
REQ-029 The carry out of the MSB SHALL NOT wrap around; bits beyond WIDTH SHALL be discarded except as c_out.
REQ-030 When LAT=1 the block SHALL degenerate to a single registered adder with identical handshake behaviour.

Reset
REQ-031 Asserting rst SHALL immediately clear all valid bits, forcing out_valid=0, s=0, c_out=0 and ovf=0.
REQ-032 While rst=1, in_ready SHALL be 1 (out_valid=0), but no beat SHALL be captured.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight beats, and no stale result SHALL appear after reset release.
REQ-034 The first beat SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=16, SLICE_GROUPS=2, LAT=2)
REQ-035 Bench SHALL apply a=FFFF, b=0001, c0=0, sub=0 and require, 2 cycles later, s=0000, c_out=1, ovf=0; this exercises carry across both slices.
REQ-036 Bench SHALL apply a=8000, b=0001, sub=1 and require s=7FFF, c_out=1, ovf=1; it SHALL also apply a=7FFF, b=0001, c0=0, sub=0 and require s=8000, c_out=0, ovf=1.
REQ-037 Bench SHALL stream 100 random beats back-to-back with out_ready=1 and require results in order, one per cycle, matching the reference model, with in_ready constantly 1.
REQ-038 Bench SHALL hold out_ready=0 with 3 beats offered and require in_ready=0 after the pipeline fills and outputs stable; on out_ready=1 all 3 beats SHALL drain in order with none lost or duplicated.
REQ-039 Bench SHALL assert rst for one cycle while 2 beats are in flight and require out_valid=0 immediately, and no output from those beats afterward.
REQ-040 Bench SHALL sweep WIDTH=8/SLICE_GROUPS=2 (LAT=1) and WIDTH=32/SLICE_GROUPS=1 (LAT=8), checking latency equals LAT and exhaustive or random results are correct.
